// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: the error record handed to error capture and error-buffer defaults.
package rv_iopmp_pkg;

  localparam int unsigned ERR_BUF_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        error_detected;
    logic [2:0]  etype;
    logic [1:0]  ttype;
    logic [5:0]  rrid;
    logic [7:0]  eid;
    logic [31:0] addr;
  } error_capture_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/rv_iopmp_error_buffer_if.sv
// Error path between matching logic, the error buffer and error capture.
interface rv_iopmp_error_buffer_if;
  rv_iopmp_pkg::error_capture_t err_i;
  logic                         ip_i;
  rv_iopmp_pkg::error_capture_t err_o;

  modport slave  (input  err_i, input  ip_i, output err_o);
  modport master (output err_i, output ip_i, input  err_o);
endinterface

// File: rtl/rv_iopmp_err_fifo.sv
// Generic register-based FIFO; read data comes straight from the storage registers.
module rv_iopmp_err_fifo
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  fifo_state_e      state;
  logic             do_push, do_pop;

  // Occupancy class is purely a function of the count.
  always_comb begin
    state = FIFO_PARTIAL;
    if (count == '0)              state = FIFO_EMPTY;
    else if (count == CW'(DEPTH)) state = FIFO_FULL;
  end

  assign full_o  = (state == FIFO_FULL);
  assign empty_o = (state == FIFO_EMPTY);
  assign count_o = count;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/rv_iopmp_error_buffer.sv
// Queues violations from one matching instance until error capture can log them;
// counts and flags errors lost to overflow.
module rv_iopmp_error_buffer
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned DEPTH     = ERR_BUF_DEPTH_DEFAULT,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        clr_i,
  rv_iopmp_error_buffer_if.slave      bus,
  output logic                        overflow_o,
  output logic [CNT_WIDTH-1:0]        drop_cnt_o,
  output logic [$clog2(DEPTH):0]      level_o
);

  localparam int unsigned W = $bits(error_capture_t);

  logic         push, pop, drop;
  logic         full, empty;
  logic [W-1:0] head;

  rv_iopmp_err_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (bus.err_i),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (level_o)
  );

  // Capture logs the head in the same cycle it is accepted, so accept doubles as pop.
  assign push = enable_i & bus.err_i.error_detected;
  assign pop  = ~empty & ~bus.ip_i;
  assign drop = push & full & ~pop;

  assign bus.err_o = empty ? '0 : error_capture_t'(head);

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (clr_i)             drop_cnt_o <= CNT_WIDTH'(1);
      else if (~&drop_cnt_o) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
    end else if (clr_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_rv_iopmp_error_buffer.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic vs a queue model.
module tb_rv_iopmp_error_buffer;
  import rv_iopmp_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, clr;
  logic       ovf, ovf2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [2:0] level, level2;

  int checks = 0;
  int errors = 0;

  rv_iopmp_error_buffer_if bus ();
  rv_iopmp_error_buffer_if bus2 ();

  assign bus2.err_i = bus.err_i;
  assign bus2.ip_i  = bus.ip_i;

  rv_iopmp_error_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clr_i(clr), .bus(bus),
    .overflow_o(ovf), .drop_cnt_o(cnt8), .level_o(level)
  );

  rv_iopmp_error_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clr_i(clr), .bus(bus2),
    .overflow_o(ovf2), .drop_cnt_o(cnt2), .level_o(level2)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending records and an unbounded drop tally.
  error_capture_t q[$];
  int             drops;
  bit             m_ovf;

  typedef struct {
    logic        en;
    logic        vld;
    logic [31:0] addr;
    logic        ip;
    logic        clr;
    int          exp_lvl;
    logic        exp_vld;
    logic [31:0] exp_addr;
    logic        exp_ovf;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic int sat(int d, int w);
    int m = (1 << w) - 1;
    return (d > m) ? m : d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    error_capture_t exp_err;
    exp_err = (q.size() > 0) ? q[0] : '0;
    chk("err_o",       64'(bus.err_o),  64'(exp_err));
    chk("err_o_w2",    64'(bus2.err_o), 64'(exp_err));
    chk("level_o",     64'(level),      64'(q.size()));
    chk("level_o_w2",  64'(level2),     64'(q.size()));
    chk("overflow_o",  64'(ovf),        64'(m_ovf));
    chk("overflow_w2", 64'(ovf2),       64'(m_ovf));
    chk("drop_cnt_w8", 64'(cnt8),       64'(sat(drops, 8)));
    chk("drop_cnt_w2", 64'(cnt2),       64'(sat(drops, 2)));
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then compare.
  task automatic step(input logic en, input error_capture_t e, input logic ip, input logic c);
    bit pop, push, drop;
    enable    = en;
    bus.err_i = e;
    bus.ip_i  = ip;
    clr       = c;
    pop  = (q.size() > 0) && !ip;
    push = en && e.error_detected;
    drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(e);
      else drop = 1'b1;
    end
    if (drop) begin
      drops = c ? 1 : drops + 1;
      m_ovf = 1'b1;
    end else if (c) begin
      drops = 0;
      m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  function automatic error_capture_t mk(input logic vld, input logic [31:0] addr);
    error_capture_t e = '0;
    e.error_detected = vld;
    e.addr           = addr;
    e.eid            = addr[7:0];
    return e;
  endfunction

  function automatic vec_t v(input logic en, input logic vld, input logic [31:0] addr,
                             input logic ip, input logic c, input int lvl, input logic evld,
                             input logic [31:0] eaddr, input logic eovf, input int ecnt);
    vec_t r;
    r.en = en; r.vld = vld; r.addr = addr; r.ip = ip; r.clr = c;
    r.exp_lvl = lvl; r.exp_vld = evld; r.exp_addr = eaddr; r.exp_ovf = eovf; r.exp_cnt = ecnt;
    return r;
  endfunction

  initial begin
    error_capture_t e;
    logic [63:0]    r;
    int             ip_bias;

    vecs.push_back(v(1, 1, 32'h8000_1000, 0, 0, 1, 1, 32'h8000_1000, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(v(1, 1, 32'h10,        1, 0, 1, 1, 32'h10,        0, 0));
    vecs.push_back(v(1, 1, 32'h20,        1, 0, 2, 1, 32'h10,        0, 0));
    vecs.push_back(v(1, 1, 32'h30,        1, 0, 3, 1, 32'h10,        0, 0));
    vecs.push_back(v(1, 1, 32'h40,        1, 0, 4, 1, 32'h10,        0, 0));
    vecs.push_back(v(1, 1, 32'h91,        1, 0, 4, 1, 32'h10,        1, 1));
    vecs.push_back(v(1, 1, 32'h92,        1, 0, 4, 1, 32'h10,        1, 2));
    vecs.push_back(v(1, 1, 32'h93,        1, 0, 4, 1, 32'h10,        1, 3));
    vecs.push_back(v(1, 0, 32'h0,         1, 1, 4, 1, 32'h10,        0, 0));
    vecs.push_back(v(1, 1, 32'h50,        0, 0, 4, 1, 32'h20,        0, 0));
    vecs.push_back(v(1, 0, 32'h0,         0, 0, 3, 1, 32'h30,        0, 0));
    vecs.push_back(v(1, 0, 32'h0,         1, 0, 3, 1, 32'h30,        0, 0));
    vecs.push_back(v(1, 0, 32'h0,         0, 0, 2, 1, 32'h40,        0, 0));
    vecs.push_back(v(1, 0, 32'h0,         0, 0, 1, 1, 32'h50,        0, 0));
    vecs.push_back(v(1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(v(0, 1, 32'h77,        0, 0, 0, 0, 32'h0,         0, 0));

    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; bus.err_i = '0; bus.ip_i = 1'b0;
    drops = 0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_model();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, mk(vecs[i].vld, vecs[i].addr), vecs[i].ip, vecs[i].clr);
      chk($sformatf("vec%0d level", i), 64'(level),             64'(vecs[i].exp_lvl));
      chk($sformatf("vec%0d valid", i), 64'(bus.err_o.error_detected), 64'(vecs[i].exp_vld));
      chk($sformatf("vec%0d addr", i),  64'(bus.err_o.addr),    64'(vecs[i].exp_addr));
      chk($sformatf("vec%0d ovf", i),   64'(ovf),               64'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d cnt", i),   64'(cnt8),              64'(vecs[i].exp_cnt));
    end

    // Saturation on the narrow counter, then a clear racing a drop.
    for (int i = 0; i < 4; i++) step(1, mk(1, 32'h100 + 32'(i)), 1, 0);
    for (int i = 0; i < 5; i++) step(1, mk(1, 32'h200 + 32'(i)), 1, 0);
    chk("sat cnt_w2", 64'(cnt2), 64'd3);
    chk("sat cnt_w8", 64'(cnt8), 64'd5);
    chk("sat head",   64'(bus.err_o.addr), 64'h100);
    step(1, mk(1, 32'h300), 1, 1);
    chk("race cnt_w2", 64'(cnt2), 64'd1);
    chk("race cnt_w8", 64'(cnt8), 64'd1);
    chk("race ovf",    64'(ovf),  64'd1);
    step(1, mk(0, 32'h0), 0, 0);
    chk("race level",  64'(level), 64'd3);

    // Asynchronous reset between clock edges with entries still queued.
    enable = 1'b0; bus.err_i = '0; bus.ip_i = 1'b1; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 64'(bus.err_o.error_detected), 64'd0);
    chk("arst err_o", 64'(bus.err_o), 64'd0);
    chk("arst level", 64'(level), 64'd0);
    chk("arst cnt",   64'(cnt8),  64'd0);
    chk("arst ovf",   64'(ovf),   64'd0);
    q.delete(); drops = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_model();

    // Randomized traffic with the ip_i stall probability varied per block.
    for (int b = 0; b < 8; b++) begin
      ip_bias = (b % 4) * 30;
      for (int i = 0; i < 200; i++) begin
        r = {$urandom(), $urandom()};
        e = error_capture_t'(r[$bits(error_capture_t)-1:0]);
        step($urandom_range(0, 9) != 0, e, $urandom_range(0, 99) < ip_bias,
             $urandom_range(0, 39) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
